// File: rtl/cu_write_arbiter_control.sv
// Round-robin arbiter sharing the CU write path among NUM_REQ write-engine controls, with credit-limited issue.
// Optional build macro WRITE_ARB_FIXED_PRIORITY_EN: requester 0 wins whenever valid; the rest stay round-robin.
`timescale 1ns/1ps
module cu_write_arbiter_control #(
    parameter int NUM_REQ         = 4,
    parameter int CMD_W           = 128,
    parameter int DATA_W          = 512,
    parameter int MAX_OUTSTANDING = 32,
    parameter int CNT_W           = 6,
    localparam int IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                       clock,
    input  logic                       rst,
    input  logic                       enabled_in,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*CMD_W-1:0]   req_cmd,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_0,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_1,
    output logic [NUM_REQ-1:0]         req_ack,
    input  logic                       out_alfull,
    input  logic                       write_response_valid,
    output logic [CMD_W-1:0]           write_command_out,
    output logic [DATA_W-1:0]          write_data_0_out,
    output logic [DATA_W-1:0]          write_data_1_out,
    output logic                       out_valid,
    output logic [CNT_W-1:0]           outstanding,
    output logic [IDX_W-1:0]           last_grant,
    output logic [1:0]                 fsm_state
);

    // Handshake: a requester holds req_valid and its bundle stable until it sees
    // req_ack for one cycle; the whole bundle (cmd + both beats) moves on that ack.

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

    state_t             state;
    logic               enabled;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   winner;
    logic [IDX_W-1:0]   idx;
    logic               found;
    logic               can_issue;
    logic               resp_dec;

    logic [CMD_W-1:0]   cmd_arr   [NUM_REQ];
    logic [DATA_W-1:0]  data0_arr [NUM_REQ];
    logic [DATA_W-1:0]  data1_arr [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign cmd_arr[g]   = req_cmd[g*CMD_W +: CMD_W];
        assign data0_arr[g] = req_data_0[g*DATA_W +: DATA_W];
        assign data1_arr[g] = req_data_1[g*DATA_W +: DATA_W];
    end

    // Scan starts one past the last winner so the previous winner goes last.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = IDX_W'((int'(ptr) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`ifdef WRITE_ARB_FIXED_PRIORITY_EN
        if (req_valid[0]) begin
            winner = '0;
        end
`endif
    end

    assign can_issue = (state == ARB) && !out_alfull && (outstanding < MAX_CNT) && found;
    assign resp_dec  = write_response_valid && (outstanding != '0);
    assign fsm_state = state;

    always_comb begin
        req_ack = '0;
        if (can_issue) begin
            req_ack[winner] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            enabled           <= 1'b0;
            ptr               <= '0;
            last_grant        <= '0;
            outstanding       <= '0;
            out_valid         <= 1'b0;
            write_command_out <= '0;
            write_data_0_out  <= '0;
            write_data_1_out  <= '0;
        end else begin
            enabled <= enabled_in;

            case (state)
                IDLE:    if (enabled) state <= ARB;
                ARB:     if (!enabled) state <= DRAIN;
                DRAIN: begin
                    if (enabled) begin
                        state <= ARB;
                    end else if (outstanding == '0) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // An accept and a response in the same cycle cancel out.
            if (can_issue && !resp_dec) begin
                outstanding <= outstanding + CNT_W'(1);
            end else if (!can_issue && resp_dec) begin
                outstanding <= outstanding - CNT_W'(1);
            end

            out_valid <= can_issue;
            if (can_issue) begin
                write_command_out <= cmd_arr[winner];
                write_data_0_out  <= data0_arr[winner];
                write_data_1_out  <= data1_arr[winner];
                last_grant        <= winner;
`ifdef WRITE_ARB_FIXED_PRIORITY_EN
                if (winner != '0) begin
                    ptr <= winner;
                end
`else
                ptr <= winner;
`endif
            end else begin
                write_command_out <= '0;
                write_data_0_out  <= '0;
                write_data_1_out  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_cu_write_arbiter_control.sv
// Directed bench for cu_write_arbiter_control: a MAX_OUTSTANDING=32 instance plus a MAX_OUTSTANDING=4 instance.
`timescale 1ns/1ps
module tb_cu_write_arbiter_control;
    localparam int NR = 4;
    localparam int CW = 16;
    localparam int DW = 32;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARB   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic clock = 1'b0;
    logic rst = 1'b1;
    logic enabled_in = 1'b0;
    logic out_alfull = 1'b0;
    logic write_response_valid = 1'b0;
    logic [NR-1:0]    req_valid = '0;
    logic [NR*CW-1:0] req_cmd;
    logic [NR*DW-1:0] req_data_0;
    logic [NR*DW-1:0] req_data_1;

    logic [NR-1:0] ack, s_ack;
    logic [CW-1:0] cmd_o, s_cmd_o;
    logic [DW-1:0] d0_o, d1_o, s_d0_o, s_d1_o;
    logic ov, s_ov;
    logic [5:0] outst, s_outst;
    logic [1:0] lg, s_lg, st, s_st;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    cu_write_arbiter_control #(.NUM_REQ(NR), .CMD_W(CW), .DATA_W(DW), .MAX_OUTSTANDING(32), .CNT_W(6)) dut (
        .clock(clock), .rst(rst), .enabled_in(enabled_in), .req_valid(req_valid),
        .req_cmd(req_cmd), .req_data_0(req_data_0), .req_data_1(req_data_1), .req_ack(ack),
        .out_alfull(out_alfull), .write_response_valid(write_response_valid),
        .write_command_out(cmd_o), .write_data_0_out(d0_o), .write_data_1_out(d1_o),
        .out_valid(ov), .outstanding(outst), .last_grant(lg), .fsm_state(st));

    cu_write_arbiter_control #(.NUM_REQ(NR), .CMD_W(CW), .DATA_W(DW), .MAX_OUTSTANDING(4), .CNT_W(6)) dut_small (
        .clock(clock), .rst(rst), .enabled_in(enabled_in), .req_valid(req_valid),
        .req_cmd(req_cmd), .req_data_0(req_data_0), .req_data_1(req_data_1), .req_ack(s_ack),
        .out_alfull(out_alfull), .write_response_valid(write_response_valid),
        .write_command_out(s_cmd_o), .write_data_0_out(s_d0_o), .write_data_1_out(s_d1_o),
        .out_valid(s_ov), .outstanding(s_outst), .last_grant(s_lg), .fsm_state(s_st));

    function automatic logic [CW-1:0] exp_cmd(input int i);
        return 16'hC0A0 + 16'(i);
    endfunction
    function automatic logic [DW-1:0] exp_d0(input int i);
        return 32'hD000_0000 + 32'(i * 17);
    endfunction
    function automatic logic [DW-1:0] exp_d1(input int i);
        return 32'hE000_0000 + 32'(i * 33);
    endfunction

    // Inputs change 1 ns after the rising edge; registered outputs are read there too.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic reset_and_enable();
        rst = 1'b1;
        req_valid = '0;
        enabled_in = 1'b0;
        out_alfull = 1'b0;
        write_response_valid = 1'b0;
        tick();
        rst = 1'b0;
        enabled_in = 1'b1;
        tick();
        tick();
    endtask

    task automatic test_reset();
        logic [NR-1:0] exp_ack;
        rst = 1'b1;
        enabled_in = 1'b1;
        req_valid = 4'hF;
        tick();
        tick();
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL reset_ack: got %b expected 0000", ack); end
        n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b expected 0", ov); end
        n_cmp++; if ({cmd_o, d0_o, d1_o} !== '0) begin n_err++; $display("FAIL reset_data: got %h %h %h expected 0", cmd_o, d0_o, d1_o); end
        n_cmp++; if (outst !== 6'd0) begin n_err++; $display("FAIL reset_outstanding: got %0d expected 0", outst); end
        n_cmp++; if (lg !== 2'd0) begin n_err++; $display("FAIL reset_last_grant: got %0d expected 0", lg); end
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", st, ST_IDLE); end
        rst = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            exp_ack = (c == 3) ? 4'b0010 : 4'b0000;
            @(negedge clock);
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL first_grant_ack cyc%0d: got %b expected %b", c, ack, exp_ack); end
            tick();
        end
        n_cmp++; if (ov !== 1'b1) begin n_err++; $display("FAIL first_grant_valid: got %b expected 1", ov); end
        n_cmp++; if ({cmd_o, d0_o, d1_o} !== {exp_cmd(1), exp_d0(1), exp_d1(1)}) begin
            n_err++; $display("FAIL first_grant_payload: got %h %h %h expected %h %h %h", cmd_o, d0_o, d1_o, exp_cmd(1), exp_d0(1), exp_d1(1)); end
        n_cmp++; if (lg !== 2'd1) begin n_err++; $display("FAIL first_grant_last_grant: got %0d expected 1", lg); end
        n_cmp++; if (outst !== 6'd1) begin n_err++; $display("FAIL first_grant_outstanding: got %0d expected 1", outst); end
    endtask

    task automatic test_round_robin();
        int w;
        reset_and_enable();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            w = (k + 1) % NR;
            @(negedge clock);
            n_cmp++; if (ack !== 4'(1 << w)) begin n_err++; $display("FAIL rr_ack k%0d: got %b expected %b", k, ack, 4'(1 << w)); end
            tick();
            n_cmp++; if ({ov, cmd_o, d0_o, d1_o} !== {1'b1, exp_cmd(w), exp_d0(w), exp_d1(w)}) begin
                n_err++; $display("FAIL rr_payload k%0d: got %b %h %h %h expected 1 %h %h %h", k, ov, cmd_o, d0_o, d1_o, exp_cmd(w), exp_d0(w), exp_d1(w)); end
            n_cmp++; if (lg !== 2'(w)) begin n_err++; $display("FAIL rr_last_grant k%0d: got %0d expected %0d", k, lg, w); end
        end
        req_valid = '0;
        n_cmp++; if (outst !== 6'd8) begin n_err++; $display("FAIL rr_outstanding: got %0d expected 8", outst); end
    endtask

    task automatic test_single_requester();
        reset_and_enable();
        req_valid = 4'b0100;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            n_cmp++; if (ack !== 4'b0100) begin n_err++; $display("FAIL single_ack k%0d: got %b expected 0100", k, ack); end
            tick();
            n_cmp++; if ({ov, cmd_o, d0_o, d1_o} !== {1'b1, exp_cmd(2), exp_d0(2), exp_d1(2)}) begin
                n_err++; $display("FAIL single_payload k%0d: got %b %h %h %h", k, ov, cmd_o, d0_o, d1_o); end
        end
        req_valid = '0;
        n_cmp++; if (outst !== 6'd10) begin n_err++; $display("FAIL single_outstanding: got %0d expected 10", outst); end
        @(negedge clock);
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL single_idle_ack: got %b expected 0000", ack); end
        tick();
        n_cmp++; if ({ov, cmd_o, d0_o, d1_o} !== '0) begin n_err++; $display("FAIL single_zeroed: got %b %h %h %h expected all 0", ov, cmd_o, d0_o, d1_o); end
        n_cmp++; if (lg !== 2'd2) begin n_err++; $display("FAIL single_last_grant_held: got %0d expected 2", lg); end
    endtask

    task automatic test_accept_with_response();
        reset_and_enable();
        req_valid = 4'b0010;
        tick();
        write_response_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (ack !== 4'b0010) begin n_err++; $display("FAIL acc_resp_ack: got %b expected 0010", ack); end
        tick();
        n_cmp++; if (outst !== 6'd1) begin n_err++; $display("FAIL acc_resp_unchanged: got %0d expected 1", outst); end
        req_valid = '0;
        tick();
        n_cmp++; if (outst !== 6'd0) begin n_err++; $display("FAIL resp_decrement: got %0d expected 0", outst); end
        tick();
        n_cmp++; if (outst !== 6'd0) begin n_err++; $display("FAIL resp_saturate_zero: got %0d expected 0", outst); end
        write_response_valid = 1'b0;
    endtask

    task automatic test_credit_limit();
        logic [NR-1:0] exp_ack;
        reset_and_enable();
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) begin
            exp_ack = (k < 4) ? 4'(1 << ((k + 1) % NR)) : 4'b0000;
            @(negedge clock);
            n_cmp++; if (s_ack !== exp_ack) begin n_err++; $display("FAIL credit_ack k%0d: got %b expected %b", k, s_ack, exp_ack); end
            tick();
        end
        n_cmp++; if (s_outst !== 6'd4) begin n_err++; $display("FAIL credit_full: got %0d expected 4", s_outst); end
        n_cmp++; if (s_ov !== 1'b0) begin n_err++; $display("FAIL credit_stall_valid: got %b expected 0", s_ov); end
        write_response_valid = 1'b1;
        @(negedge clock);
        n_cmp++; if (s_ack !== 4'b0000) begin n_err++; $display("FAIL credit_resp_same_cycle_ack: got %b expected 0000", s_ack); end
        tick();
        write_response_valid = 1'b0;
        n_cmp++; if (s_outst !== 6'd3) begin n_err++; $display("FAIL credit_freed: got %0d expected 3", s_outst); end
        @(negedge clock);
        n_cmp++; if (s_ack !== 4'b0010) begin n_err++; $display("FAIL credit_reuse_ack: got %b expected 0010", s_ack); end
        tick();
        n_cmp++; if ({s_ov, s_outst, s_cmd_o} !== {1'b1, 6'd4, exp_cmd(1)}) begin
            n_err++; $display("FAIL credit_reuse_out: got %b %0d %h expected 1 4 %h", s_ov, s_outst, s_cmd_o, exp_cmd(1)); end
        req_valid = '0;
    endtask

    task automatic test_alfull();
        reset_and_enable();
        req_valid = 4'b1000;
        @(negedge clock);
        n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL alfull_pre_ack: got %b expected 1000", ack); end
        tick();
        out_alfull = 1'b1;
        #1;
        n_cmp++; if ({ov, cmd_o, d1_o} !== {1'b1, exp_cmd(3), exp_d1(3)}) begin
            n_err++; $display("FAIL alfull_registered_emitted: got %b %h %h expected 1 %h %h", ov, cmd_o, d1_o, exp_cmd(3), exp_d1(3)); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL alfull_ack k%0d: got %b expected 0000", k, ack); end
            tick();
            n_cmp++; if (ov !== 1'b0) begin n_err++; $display("FAIL alfull_valid k%0d: got %b expected 0", k, ov); end
        end
        out_alfull = 1'b0;
        @(negedge clock);
        n_cmp++; if (ack !== 4'b1000) begin n_err++; $display("FAIL alfull_resume_ack: got %b expected 1000", ack); end
        tick();
        n_cmp++; if ({ov, outst} !== {1'b1, 6'd2}) begin n_err++; $display("FAIL alfull_resume_out: got %b %0d expected 1 2", ov, outst); end
        req_valid = '0;
    endtask

    task automatic test_drain();
        reset_and_enable();
        req_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++; if (ack !== 4'(1 << (k + 1))) begin n_err++; $display("FAIL drain_fill_ack k%0d: got %b expected %b", k, ack, 4'(1 << (k + 1))); end
            tick();
        end
        req_valid = '0;
        enabled_in = 1'b0;
        tick();
        n_cmp++; if (st !== ST_ARB) begin n_err++; $display("FAIL drain_enable_latency: got %0d expected %0d", st, ST_ARB); end
        tick();
        n_cmp++; if ({st, outst} !== {ST_DRAIN, 6'd3}) begin n_err++; $display("FAIL drain_entry: got st %0d outst %0d expected %0d 3", st, outst, ST_DRAIN); end
        req_valid = 4'hF;
        write_response_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL drain_ack k%0d: got %b expected 0000", k, ack); end
            tick();
            n_cmp++; if (outst !== 6'(2 - k)) begin n_err++; $display("FAIL drain_count k%0d: got %0d expected %0d", k, outst, 2 - k); end
        end
        write_response_valid = 1'b0;
        @(negedge clock);
        n_cmp++; if (ack !== 4'b0000) begin n_err++; $display("FAIL drain_last_ack: got %b expected 0000", ack); end
        tick();
        n_cmp++; if (st !== ST_IDLE) begin n_err++; $display("FAIL drain_to_idle: got %0d expected %0d", st, ST_IDLE); end
        req_valid = '0;
    endtask

    task automatic test_priority_mode();
        logic [NR-1:0] exp_ack;
        reset_and_enable();
        req_valid = 4'b1001;
        for (int k = 0; k < 4; k++) begin
`ifdef WRITE_ARB_FIXED_PRIORITY_EN
            exp_ack = 4'b0001;
`else
            exp_ack = (k % 2 == 0) ? 4'b1000 : 4'b0001;
`endif
            @(negedge clock);
            n_cmp++; if (ack !== exp_ack) begin n_err++; $display("FAIL prio_ack k%0d: got %b expected %b", k, ack, exp_ack); end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_mid_reset();
        reset_and_enable();
        req_valid = 4'hF;
        tick();
        tick();
        rst = 1'b1;
        #1;
        n_cmp++; if ({ov, outst, lg, st, ack} !== '0) begin
            n_err++; $display("FAIL mid_reset: got ov %b outst %0d lg %0d st %0d ack %b expected all 0", ov, outst, lg, st, ack); end
        n_cmp++; if ({cmd_o, d0_o, d1_o} !== '0) begin n_err++; $display("FAIL mid_reset_data: got %h %h %h expected 0", cmd_o, d0_o, d1_o); end
        tick();
        rst = 1'b0;
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NR; i++) begin
            req_cmd[i*CW +: CW]    = exp_cmd(i);
            req_data_0[i*DW +: DW] = exp_d0(i);
            req_data_1[i*DW +: DW] = exp_d1(i);
        end
        test_reset();
        test_round_robin();
        test_single_requester();
        test_accept_with_response();
        test_credit_limit();
        test_alfull();
        test_drain();
        test_priority_mode();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
